// File: rtl/vend_datapath.sv
// Vending-machine coin datapath: latches a price, accumulates coins with saturation,
// and reports price-met, change due, coin count and reject/protocol-error pulses.
module vend_datapath #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tc,
  input  logic          tw,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  s,
  output logic          tm,
  output logic [W-1:0]  tot,
  output logic [W-1:0]  chg,
  output logic          ovf,
  output logic [CW-1:0] ncoin,
  output logic          rej,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PAID  = 2'd2
  } state_t;

  localparam logic [W-1:0]  TOT_MAX = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state;
  logic [W-1:0]  r_tot;
  logic [W-1:0]  r_s;
  logic [CW-1:0] r_ncoin;
  logic          r_ovf;
  logic          r_rej;
  logic          r_err;

  logic [W:0]    w_sum;
  logic          w_price_met;

  // One extra bit on the sum exposes the carry that signals saturation.
  assign w_sum       = {1'b0, r_tot} + {1'b0, a};
  assign w_price_met = (r_tot >= r_s);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the latched price, gets a reset value so
    // the block comes out of reset in a fully defined IDLE condition.
    if (!rst_n) begin
      r_state <= IDLE;
      r_tot   <= '0;
      r_s     <= '0;
      r_ncoin <= '0;
      r_ovf   <= 1'b0;
      r_rej   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      r_rej <= 1'b0;
      r_err <= 1'b0;
      if (tc) begin
        r_tot   <= '0;
        r_ncoin <= '0;
        r_ovf   <= 1'b0;
        r_s     <= s;
        r_state <= ACCUM;
        r_err   <= tw;
      end else if (tw) begin
        if (r_state == ACCUM) begin
          if (w_sum[W]) begin
            r_tot <= TOT_MAX;
            r_ovf <= 1'b1;
          end else begin
            r_tot <= w_sum[W-1:0];
          end
          if (r_ncoin != CNT_MAX) r_ncoin <= r_ncoin + 1'b1;
        end else begin
          r_rej <= 1'b1;
        end
      end else if (r_state == ACCUM && w_price_met) begin
        r_state <= PAID;
      end
    end
  end

  // Outputs decode registers only; PAID is entered only with tot >= price and
  // tot is frozen there, so the subtraction cannot underflow.
  assign tm    = (r_state == PAID);
  assign chg   = (r_state == PAID) ? (r_tot - r_s) : '0;
  assign tot   = r_tot;
  assign ovf   = r_ovf;
  assign ncoin = r_ncoin;
  assign rej   = r_rej;
  assign err   = r_err;

endmodule

// File: tb/tb_vend_datapath.sv
// Directed testbench for vend_datapath: payment, overpayment, saturation,
// collision, asynchronous reset and zero-price scenarios.
module tb_vend_datapath;

  logic       clk;
  logic       rst_n;
  logic       tc;
  logic       tw;
  logic [7:0] a;
  logic [7:0] s;
  logic       tm;
  logic [7:0] tot;
  logic [7:0] chg;
  logic       ovf;
  logic [3:0] ncoin;
  logic       rej;
  logic       err;

  int total = 0;
  int bad   = 0;

  vend_datapath #(.W(8), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc),
    .tw    (tw),
    .a     (a),
    .s     (s),
    .tm    (tm),
    .tot   (tot),
    .chg   (chg),
    .ovf   (ovf),
    .ncoin (ncoin),
    .rej   (rej),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [7:0] price);
    tc = 1'b1;
    s  = price;
    tick();
    tc = 1'b0;
  endtask

  task automatic do_coin(input logic [7:0] value);
    tw = 1'b1;
    a  = value;
    tick();
    tw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tc = 1'b0; tw = 1'b0; a = '0; s = '0;
    #1;
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL reset_tm got=%0d exp=0", tm); end
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL reset_tot got=%0d exp=0", tot); end
    total++; if (chg !== 8'd0)   begin bad++; $display("FAIL reset_chg got=%0d exp=0", chg); end
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%0d exp=0", ovf); end
    total++; if (ncoin !== 4'd0) begin bad++; $display("FAIL reset_ncoin got=%0d exp=0", ncoin); end
    total++; if ({rej, err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {rej, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    do_coin(8'd40);
    total++; if (rej !== 1'b1)   begin bad++; $display("FAIL idle_rej got=%0d exp=1", rej); end
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL idle_tot got=%0d exp=0", tot); end
    total++; if (ncoin !== 4'd0) begin bad++; $display("FAIL idle_ncoin got=%0d exp=0", ncoin); end
    tick();
    total++; if (rej !== 1'b0)   begin bad++; $display("FAIL idle_rej_clear got=%0d exp=0", rej); end
  endtask

  task automatic test_exact();
    do_clear(8'd150);
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL exact_clr_tot got=%0d exp=0", tot); end
    do_coin(8'd100);
    total++; if (tot !== 8'd100) begin bad++; $display("FAIL exact_tot1 got=%0d exp=100", tot); end
    do_coin(8'd50);
    total++; if (tot !== 8'd150) begin bad++; $display("FAIL exact_tot2 got=%0d exp=150", tot); end
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL exact_tm_early got=%0d exp=0", tm); end
    tick();
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL exact_tm got=%0d exp=1", tm); end
    total++; if (chg !== 8'd0)   begin bad++; $display("FAIL exact_chg got=%0d exp=0", chg); end
    total++; if (ncoin !== 4'd2) begin bad++; $display("FAIL exact_ncoin got=%0d exp=2", ncoin); end
  endtask

  task automatic test_overpay();
    do_clear(8'd120);
    do_coin(8'd100);
    do_coin(8'd50);
    total++; if (tot !== 8'd150) begin bad++; $display("FAIL over_tot got=%0d exp=150", tot); end
    tick();
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL over_tm got=%0d exp=1", tm); end
    total++; if (chg !== 8'd30)  begin bad++; $display("FAIL over_chg got=%0d exp=30", chg); end
    do_coin(8'd25);
    total++; if (rej !== 1'b1)   begin bad++; $display("FAIL over_rej got=%0d exp=1", rej); end
    total++; if (tot !== 8'd150) begin bad++; $display("FAIL over_frozen_tot got=%0d exp=150", tot); end
    total++; if (ncoin !== 4'd2) begin bad++; $display("FAIL over_frozen_ncoin got=%0d exp=2", ncoin); end
    tick();
    total++; if (rej !== 1'b0)   begin bad++; $display("FAIL over_rej_pulse got=%0d exp=0", rej); end
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL over_tm_hold got=%0d exp=1", tm); end
  endtask

  task automatic test_saturation();
    do_clear(8'd255);
    do_coin(8'd200);
    total++; if (tot !== 8'd200) begin bad++; $display("FAIL sat_tot1 got=%0d exp=200", tot); end
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL sat_ovf_early got=%0d exp=0", ovf); end
    do_coin(8'd100);
    total++; if (tot !== 8'd255) begin bad++; $display("FAIL sat_tot got=%0d exp=255", tot); end
    total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL sat_ovf got=%0d exp=1", ovf); end
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL sat_tm_early got=%0d exp=0", tm); end
    tick();
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL sat_tm got=%0d exp=1", tm); end
    total++; if (chg !== 8'd0)   begin bad++; $display("FAIL sat_chg got=%0d exp=0", chg); end
    total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL sat_ovf_sticky got=%0d exp=1", ovf); end
    do_clear(8'd10);
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL sat_clr_ovf got=%0d exp=0", ovf); end
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL sat_clr_tot got=%0d exp=0", tot); end
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL sat_clr_tm got=%0d exp=0", tm); end
  endtask

  task automatic test_collision();
    do_clear(8'd200);
    do_coin(8'd60);
    total++; if (tot !== 8'd60)  begin bad++; $display("FAIL col_tot_pre got=%0d exp=60", tot); end
    tc = 1'b1; tw = 1'b1; a = 8'd50; s = 8'd90;
    tick();
    tc = 1'b0; tw = 1'b0;
    total++; if (err !== 1'b1)   begin bad++; $display("FAIL col_err got=%0d exp=1", err); end
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL col_tot got=%0d exp=0", tot); end
    total++; if (ncoin !== 4'd0) begin bad++; $display("FAIL col_ncoin got=%0d exp=0", ncoin); end
    tick();
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL col_err_pulse got=%0d exp=0", err); end
    do_coin(8'd100);
    tick();
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL col_new_price_tm got=%0d exp=1", tm); end
    total++; if (chg !== 8'd10)  begin bad++; $display("FAIL col_new_price_chg got=%0d exp=10", chg); end
  endtask

  task automatic test_async_reset();
    do_clear(8'd200);
    do_coin(8'd80);
    total++; if (tot !== 8'd80)  begin bad++; $display("FAIL arst_tot_pre got=%0d exp=80", tot); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL arst_tot got=%0d exp=0", tot); end
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL arst_tm got=%0d exp=0", tm); end
    total++; if (ncoin !== 4'd0) begin bad++; $display("FAIL arst_ncoin got=%0d exp=0", ncoin); end
    @(negedge clk);
    rst_n = 1'b1;
    do_coin(8'd30);
    total++; if (rej !== 1'b1)   begin bad++; $display("FAIL arst_rej got=%0d exp=1", rej); end
    total++; if (tot !== 8'd0)   begin bad++; $display("FAIL arst_tot_after got=%0d exp=0", tot); end
  endtask

  task automatic test_zero_price();
    do_clear(8'd0);
    total++; if (tm !== 1'b0)    begin bad++; $display("FAIL zero_tm_early got=%0d exp=0", tm); end
    tick();
    total++; if (tm !== 1'b1)    begin bad++; $display("FAIL zero_tm got=%0d exp=1", tm); end
    total++; if (chg !== 8'd0)   begin bad++; $display("FAIL zero_chg got=%0d exp=0", chg); end
    do_clear(8'd255);
    tw = 1'b1; a = 8'd1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        total++; if (ncoin !== 4'd15) begin bad++; $display("FAIL cnt_15 got=%0d exp=15", ncoin); end
      end
    end
    tw = 1'b0;
    total++; if (ncoin !== 4'd15) begin bad++; $display("FAIL cnt_sat got=%0d exp=15", ncoin); end
    total++; if (tot !== 8'd16)   begin bad++; $display("FAIL cnt_tot got=%0d exp=16", tot); end
    total++; if (tm !== 1'b0)     begin bad++; $display("FAIL cnt_tm got=%0d exp=0", tm); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_saturation();
    test_collision();
    test_async_reset();
    test_zero_price();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_datapath.md
VEND_DATAPATH -- requirements
Module: vend_datapath

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the coin, price and total width in bits.
REQ-002 The block SHALL have parameter CW, default 4, giving the coin-counter width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port tc  input  1  clear total and latch price, driven by the vending controller.
REQ-006 The block SHALL have port tw  input  1  add current coin value to total, driven by the vending controller.
REQ-007 The block SHALL have port a  input  W  value of the coin being added, unsigned.
REQ-008 The block SHALL have port s  input  W  product price, unsigned; sampled only on tc.
REQ-009 The block SHALL have port tm  output  1  total meets price; returned to the vending controller.
REQ-010 The block SHALL have port tot  output  W  registered running total.
REQ-011 The block SHALL have port chg  output  W  change due.
REQ-012 The block SHALL have port ovf  output  1  sticky saturation flag.
REQ-013 The block SHALL have port ncoin  output  CW  number of coins accepted since the last clear.
REQ-014 The block SHALL have port rej  output  1  one-cycle pulse: coin rejected, total unchanged.
REQ-015 The block SHALL have port err  output  1  one-cycle pulse: protocol violation.

Function
REQ-016 The FSM SHALL have states IDLE (no price latched), ACCUM (collecting) and PAID (price met).
REQ-017 When tc=1 in any state, the block SHALL on that edge set tot=0, ncoin=0, ovf=0, latch s_reg=s, and go to ACCUM.
REQ-018 When tw=1, tc=0 and state=ACCUM, the block SHALL set tot=min(tot+a, 2^W-1) on that edge; if the W+1-bit sum exceeds 2^W-1, it SHALL also set ovf=1.
REQ-019 When tw is accepted, the block SHALL increment ncoin, saturating at 2^CW-1; the ncoin wrap-around from 2^CW-1 to 0 SHALL NOT occur.
REQ-020 ACCUM SHALL go to PAID on the edge where registered tot>=s_reg and tw=0 and tc=0, giving tm exactly one cycle after tot first reaches the price.
REQ-021 If tw=1 and tot>=s_reg in the same ACCUM cycle, the coin SHALL still be added, and the PAID check SHALL repeat next cycle.
REQ-022 tm SHALL equal 1 iff state=PAID, and SHALL be a registered decode with no combinational path from inputs.
REQ-023 chg SHALL equal tot-s_reg when state=PAID, and 0 otherwise; it is never negative.
REQ-024 PAID SHALL be left only by tc or reset, and tot, ncoin and ovf SHALL be frozen in PAID.
REQ-025 tw=1 with tc=0 in IDLE or PAID SHALL leave all registers unchanged and pulse rej=1 for one cycle.
REQ-026 tc=1 and tw=1 in the same cycle SHALL apply tc only (REQ-017), discard the coin, and pulse err=1 for one cycle.
REQ-027 tw held high for N consecutive cycles in ACCUM SHALL add a N times; edge qualification of tw is the controller's job.
REQ-028 s=0 latched SHALL give PAID one cycle after tc, with chg=tot.

Reset
REQ-029 While rst_n=0, the block SHALL immediately, independent of clk, set state=IDLE, tot=0, s_reg=0, ncoin=0, ovf=0, and tm=chg=rej=err=0.
REQ-030 Reset asserted mid-accumulation SHALL discard the partial total; a tw arriving on the first edge after rst_n rises SHALL be rejected (IDLE).
REQ-031 Removal of rst_n is synchronous to clk, and its timing is guaranteed by the integrator.

Verification
REQ-032 The bench SHALL cover exact payment: tc with s=150; tw a=100; tw a=50 -> tot=100 then 150; tm=1 one cycle later; chg=0; ncoin=2.
REQ-033 The bench SHALL cover overpayment: s=120; coins 100, 50 -> tot=150, tm=1, chg=30; further tw a=25 -> rej pulse, tot stays 150.
REQ-034 The bench SHALL cover saturation: s=255; coins 200, 100 -> tot=255, ovf=1, tm=1 next cycle, chg=0; then tc -> ovf=0, tot=0.
REQ-035 The bench SHALL cover collision: in ACCUM with tot=60, drive tc=1 and tw=1 with a=50 together -> err pulse, tot=0, ncoin=0, s_reg=new s.
REQ-036 The bench SHALL cover async reset: rst_n low mid-cycle with tot=80 -> tot=0, tm=0 before the next clk edge; tw after release -> rej=1.
REQ-037 The bench SHALL cover zero price: tc with s=0 -> tm=1 one cycle later; 16 coins of a=1 at s=255 with CW=4 -> ncoin stays at 15, tot=16.
